// File: rtl/lift_car_controller.sv
// Per-car SCAN sequencer: accumulates hall/cabin requests and drives travel, door and halt timing.
// All outputs are registered; cur_floor doubles as the car's lift state for the dispatcher.
module lift_car_controller #(
  parameter int NUM_FLOORS    = 11,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic                  door_obstruct,
  input  logic                  emergency_stop,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  halted,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] served
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR, HALT} state_t;

  state_t              state, saved;
  logic [TW-1:0]       travel_tmr;
  logic [DW-1:0]       door_tmr;

  logic [NUM_FLOORS-1:0] req_all, acc, cur_bit, step_bit;
  logic [FLOOR_W-1:0]    step_floor;
  logic                  above_cur, below_cur, above_step, below_step;
  logic                  hit_cur, hit_step;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (i > 32'(f)) r = r | p[i];
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (i < 32'(f)) r = r | p[i];
    return r;
  endfunction

  always_comb begin
    req_all    = floor_req | car_req;
    acc        = pending | req_all;
    cur_bit    = NUM_FLOORS'(1) << cur_floor;
    // Stepping is clamped so the floor index can never leave 0..TOP.
    step_floor = cur_floor;
    if (dir_up && cur_floor != TOP)
      step_floor = cur_floor + FLOOR_W'(1);
    else if (!dir_up && cur_floor != '0)
      step_floor = cur_floor - FLOOR_W'(1);
    step_bit   = NUM_FLOORS'(1) << step_floor;
    above_cur  = any_above(pending, cur_floor);
    below_cur  = any_below(pending, cur_floor);
    above_step = any_above(pending, step_floor);
    below_step = any_below(pending, step_floor);
    hit_cur    = |(pending & cur_bit);
    hit_step   = |(pending & step_bit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      saved      <= IDLE;
      travel_tmr <= '0;
      door_tmr   <= '0;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      halted     <= 1'b0;
      pending    <= '0;
      served     <= '0;
    end else begin
      served  <= '0;
      pending <= acc;
      if (emergency_stop) begin
        // Timers and door_open hold; only the state is parked until release.
        if (state != HALT) saved <= state;
        state  <= HALT;
        halted <= 1'b1;
        moving <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hit_cur) begin
              state     <= DOOR;
              door_open <= 1'b1;
              door_tmr  <= DW'(DOOR_CYCLES);
              served    <= cur_bit;
              pending   <= acc & ~cur_bit;
            end else if (dir_up ? above_cur : below_cur) begin
              state      <= MOVE;
              moving     <= 1'b1;
              travel_tmr <= TW'(TRAVEL_CYCLES);
            end else if (dir_up ? below_cur : above_cur) begin
              state      <= MOVE;
              moving     <= 1'b1;
              dir_up     <= ~dir_up;
              travel_tmr <= TW'(TRAVEL_CYCLES);
            end
          end
          MOVE: begin
            if (travel_tmr <= TW'(1)) begin
              cur_floor <= step_floor;
              if (hit_step) begin
                state     <= DOOR;
                moving    <= 1'b0;
                door_open <= 1'b1;
                door_tmr  <= DW'(DOOR_CYCLES);
                served    <= step_bit;
                pending   <= acc & ~step_bit;
              end else if (dir_up ? above_step : below_step) begin
                travel_tmr <= TW'(TRAVEL_CYCLES);
              end else if (dir_up ? below_step : above_step) begin
                dir_up     <= ~dir_up;
                travel_tmr <= TW'(TRAVEL_CYCLES);
              end else begin
                state  <= IDLE;
                moving <= 1'b0;
              end
            end else begin
              travel_tmr <= travel_tmr - TW'(1);
            end
          end
          DOOR: begin
            // A call for this floor while open just keeps the door open.
            pending <= acc & ~cur_bit;
            if (door_obstruct || |(req_all & cur_bit)) begin
              door_tmr <= DW'(DOOR_CYCLES);
            end else if (door_tmr <= DW'(1)) begin
              state     <= IDLE;
              door_open <= 1'b0;
            end else begin
              door_tmr <= door_tmr - DW'(1);
            end
          end
          default: begin
            state     <= saved;
            halted    <= 1'b0;
            moving    <= (saved == MOVE);
            door_open <= (saved == DOOR);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lift_car_controller.sv
// Directed bench for lift_car_controller: hall call, sweep order, door extension,
// emergency halt, async reset and top-floor reversal with hand-computed edge timing.
module tb_lift_car_controller;

  localparam int NF = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] floor_req, car_req;
  logic          door_obstruct, emergency_stop;
  logic [3:0]    cur_floor;
  logic          dir_up, moving, door_open, halted;
  logic [NF-1:0] pending, served;

  int tests  = 0;
  int failed = 0;
  int max_floor = 0;
  int overlap   = 0;

  lift_car_controller #(
    .NUM_FLOORS(NF),
    .FLOOR_W(4),
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .floor_req(floor_req),
    .car_req(car_req),
    .door_obstruct(door_obstruct),
    .emergency_stop(emergency_stop),
    .cur_floor(cur_floor),
    .dir_up(dir_up),
    .moving(moving),
    .door_open(door_open),
    .halted(halted),
    .pending(pending),
    .served(served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n edges, sampling 1 ns after each; tracks floor range and door/motion overlap.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (int'(cur_floor) > max_floor) max_floor = int'(cur_floor);
      if (door_open && moving) overlap++;
    end
  endtask

  initial begin
    rst = 1'b0;
    floor_req = '0;
    car_req = '0;
    door_obstruct = 1'b0;
    emergency_stop = 1'b0;
    #12;
    check("rst_floor", 32'(cur_floor), 0);
    check("rst_dir", 32'(dir_up), 1);
    check("rst_flags", {29'd0, moving, door_open, halted}, 0);
    check("rst_pending", 32'(pending), 0);
    rst = 1'b1;
    tick(1);

    // Single hall call to floor 3
    floor_req = 11'h008; tick(1); floor_req = '0;
    check("t1_pend", 32'(pending), 32'h008);
    check("t1_idle", 32'(moving), 0);
    tick(1);
    check("t1_move", {30'd0, moving, dir_up}, 32'h3);
    tick(7);  check("t1_e9", 32'(cur_floor), 0);
    tick(1);  check("t1_e10", 32'(cur_floor), 1);
    tick(8);  check("t1_e18", 32'(cur_floor), 2);
    tick(7);  check("t1_e25", {28'd0, cur_floor}, 2);
    tick(1);
    check("t1_floor3", 32'(cur_floor), 3);
    check("t1_served", 32'(served), 32'h008);
    check("t1_door", {30'd0, door_open, moving}, 32'h2);
    check("t1_clear", 32'(pending), 0);
    tick(1);  check("t1_pulse", 32'(served), 0);
    tick(4);  check("t1_door_e31", 32'(door_open), 1);
    tick(1);  check("t1_door_e32", 32'(door_open), 0);

    // Sweep ordering: 8 before 2
    floor_req = 11'h100; tick(1); floor_req = '0;
    tick(17);
    check("t2_at5", {27'd0, cur_floor, dir_up}, {27'd0, 4'd5, 1'b1});
    car_req = 11'h004; floor_req = 11'h100; tick(1); car_req = '0; floor_req = '0;
    check("t2_pend", 32'(pending), 32'h104);
    tick(23);
    check("t2_serve8", 32'(served), 32'h100);
    check("t2_at8", {27'd0, cur_floor, dir_up}, {27'd0, 4'd8, 1'b1});
    tick(6);  check("t2_close", 32'(door_open), 0);
    tick(1);  check("t2_flip", {30'd0, moving, dir_up}, 32'h2);
    tick(48);
    check("t2_serve2", 32'(served), 32'h004);
    check("t2_at2", 32'(cur_floor), 2);
    check("t2_empty", 32'(pending), 0);
    tick(6);  check("t2_idle", 32'(door_open), 0);

    // Door extension at floor 4
    car_req = 11'h010; tick(1); car_req = '0;
    tick(17);
    check("t3_serve4", 32'(served), 32'h010);
    check("t3_dir", {27'd0, cur_floor, dir_up}, {27'd0, 4'd4, 1'b1});
    tick(2);
    door_obstruct = 1'b1; tick(3); door_obstruct = 1'b0;
    check("t3_obst", 32'(door_open), 1);
    tick(2);
    car_req = 11'h010; tick(1); car_req = '0;
    check("t3_nopend", 32'(pending), 0);
    tick(5);
    check("t3_e31", 32'(door_open), 1);
    check("t3_nopend2", 32'(pending), 0);
    tick(1);  check("t3_e32", 32'(door_open), 0);
    tick(1);  check("t3_stay", {30'd0, moving, door_open}, 0);

    // Emergency stop mid-hop, travel timer at 4
    car_req = 11'h040; tick(1); car_req = '0;
    tick(5);
    emergency_stop = 1'b1; tick(1);
    check("t4_halt", {29'd0, halted, moving, door_open}, 32'h4);
    tick(2);
    car_req = 11'h200; tick(1); car_req = '0;
    check("t4_accum", 32'(pending), 32'h240);
    tick(16);
    check("t4_frozen", {28'd0, cur_floor}, 4);
    check("t4_still", 32'(halted), 1);
    emergency_stop = 1'b0; tick(1);
    check("t4_resume", {30'd0, halted, moving}, 32'h1);
    tick(3);  check("t4_e30", 32'(cur_floor), 4);
    tick(1);  check("t4_e31", 32'(cur_floor), 5);

    // Asynchronous reset mid-move
    tick(2);
    #1; rst = 1'b0; #1;
    check("t5_floor", 32'(cur_floor), 0);
    check("t5_dir", 32'(dir_up), 1);
    check("t5_flags", {29'd0, moving, door_open, halted}, 0);
    check("t5_pend", 32'(pending), 0);
    check("t5_served", 32'(served), 0);
    rst = 1'b1;
    tick(1);

    // Top floor with stale upward direction, then descend to 0
    floor_req = 11'h400; tick(1); floor_req = '0;
    tick(81);
    check("t6_serve10", 32'(served), 32'h400);
    check("t6_at10", 32'(cur_floor), 10);
    tick(6);
    check("t6_stale", {30'd0, door_open, dir_up}, 32'h1);
    car_req = 11'h001; tick(1); car_req = '0;
    check("t6_pend", 32'(pending), 32'h001);
    tick(1);
    check("t6_flip", {30'd0, moving, dir_up}, 32'h2);
    tick(80);
    check("t6_serve0", 32'(served), 32'h001);
    check("t6_at0", 32'(cur_floor), 0);

    check("max_floor", 32'(max_floor), 10);
    check("door_vs_move", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
